// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and constants for the sipo_deser deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    typedef enum logic [0:0] {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Bit order selection, compared against the LSB_FIRST parameter.
    localparam bit BIT_ORDER_MSB_FIRST = 1'b0;
    localparam bit BIT_ORDER_LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : Shift register and bit counter with frame resync; flags the
//               cycle on which a word completes and presents that word.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic                     serial_valid,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         done_word,
    output logic                     word_done,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count_base;

    // A resync discards the partial word before the incoming bit is applied.
    assign shift_base = frame_start ? '0 : shreg;
    assign count_base = frame_start ? '0 : bit_count;

    generate
        if (LSB_FIRST == BIT_ORDER_LSB_FIRST) begin : g_lsb_first
            assign shifted = {serial_in, shift_base[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shifted = {shift_base[WIDTH-2:0], serial_in};
        end
    endgenerate

    // Combinational so the holding register can load on the sampling edge.
    assign word_done = serial_valid && (count_base == LAST);
    assign done_word = shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (serial_valid) begin
            shreg     <= shifted;
            bit_count <= word_done ? '0 : count_base + 1'b1;
        end else if (frame_start) begin
            shreg     <= '0;
            bit_count <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : Serial-to-parallel deserialiser with a valid/ready holding
//               register and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic                     serial_valid,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    logic [WIDTH-1:0] done_word;
    logic             word_done;
    hold_state_t      state;
    hold_state_t      state_next;
    logic             load;
    logic             drop;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_core (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .done_word    (done_word),
        .word_done    (word_done),
        .bit_count    (bit_count)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            HOLD_EMPTY: begin
                if (word_done) begin
                    load       = 1'b1;
                    state_next = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (word_ready && word_done) begin
                    load = 1'b1;
                end else if (word_ready) begin
                    state_next = HOLD_EMPTY;
                end else if (word_done) begin
                    drop = 1'b1;
                end
            end
            default: state_next = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HOLD_EMPTY;
            word_out <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                word_out <= done_word;
            end
            // A fresh overrun takes priority over a clear in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign word_valid = (state == HOLD_FULL);

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-to-parallel deserialiser with word framing and a valid/ready output handshake. It collects `WIDTH` qualified serial bits into a word in either bit order, then transfers the word to an output holding register. It sits between a serial receive pin or line interface and any word-wide consumer that may stall. Overruns are flagged, never silently hidden.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `LSB_FIRST`, 0: 0 = first received bit lands in `word_out[WIDTH-1]`; 1 = first received bit lands in `word_out[0]`.
- `clk` input 1: clock; all state changes on rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `serial_in` input 1: serial data bit.
- `serial_valid` input 1: `serial_in` is sampled only when this is high.
- `frame_start` input 1: synchronous resync; the current word restarts at bit 0.
- `word_out` output WIDTH: holding register contents.
- `word_valid` output 1: holding register is full.
- `word_ready` input 1: consumer accepts the word when `word_valid && word_ready`.
- `bit_count` output $clog2(WIDTH): number of bits already collected in the current partial word.
- `overrun` output 1: sticky; set when a completed word is dropped.
- `overrun_clr` input 1: synchronous clear of `overrun`.

## Operation
- Reset values: `word_out`=0, `word_valid`=0, `bit_count`=0, `overrun`=0, shift register=0.
- Shift path:
  - Each cycle with `serial_valid`=1, the bit is shifted in. LSB_FIRST=0 shifts left and enters at bit 0; LSB_FIRST=1 shifts right and enters at bit WIDTH-1.
  - `bit_count` increments on each shifted bit.
- Word completion:
  - A word completes on the cycle the bit is sampled while `bit_count`==WIDTH-1.
  - On completion, `bit_count` wraps to 0 on the same edge.
  - The completed word is the shift register contents including that last bit.
- Holding register is a two-state FSM, EMPTY (`word_valid`=0) and FULL (`word_valid`=1):
  - EMPTY + completion → load `word_out`, go to FULL.
  - FULL + accept, no completion → go to EMPTY.
  - FULL + accept + completion in the same cycle → load the new word and stay FULL; no overrun.
  - FULL + no accept + completion → drop the new word, keep the old `word_out`, set `overrun`.
- `word_out` is stable whenever `word_valid`=1 and no accept has occurred.
- `frame_start`:
  - Discards the partial word and forces `bit_count` to 0.
  - If `serial_valid` is also 1, that bit is taken as bit 0 of the new word, so `bit_count` becomes 1.
  - It never affects the holding register or `overrun`.
- `overrun_clr` and a new overrun in the same cycle: set wins.

## Timing
- Latency: `word_valid` rises on the clock edge that samples the last bit, so it is visible 1 cycle after the last bit is presented.
- Sustained throughput: one word per WIDTH valid cycles, with no bubbles, provided `word_ready` is held high.
- `word_ready` may be high while `word_valid`=0; this has no effect.
- Reset asserted mid-word or while FULL clears everything immediately. The first valid bit after reset release is bit 0.
- No combinational path from any input to any output.

## Structure
- Package `sipo_pkg` contains:
  - the holding FSM state enum `{HOLD_EMPTY, HOLD_FULL}`;
  - a `BIT_ORDER` constant pair `MSB_FIRST`/`LSB_FIRST`.
- Sub-module `sipo_shift_core` contains:
  - the shift register and bit counter;
  - the `frame_start` handling.
  - It outputs the completed word plus a 1-cycle `word_done` pulse.
- Top level contains the holding register, the handshake FSM and the overrun logic.

## Test plan
- Bit order, MSB-first: WIDTH=8, LSB_FIRST=0, serial 1,0,1,1,0,0,1,0 with `word_ready`=1 → `word_out`=8'hB2, `word_valid` high for 1 cycle.
- Bit order, LSB-first: same stream with LSB_FIRST=1 → `word_out`=8'h4D.
- Gaps in valid: 8 bits of 8'hA5 with `serial_valid` low every other cycle → `word_out`=8'hA5; `bit_count` holds value during gaps.
- Backpressure and overrun:
  - Hold `word_ready`=0; send 8'h11 then 8'h22 → `word_out` stays 8'h11, `overrun`=1.
  - Then `word_ready`=1 for 1 cycle → `word_valid`=0.
  - Then `overrun_clr` → `overrun`=0.
- Simultaneous accept and completion: send 8'h33 and 8'h44 back-to-back, with `word_ready` asserted exactly on 8'h44's last-bit cycle → `word_out`=8'h44, `word_valid` stays 1, `overrun`=0.
- Resync and reset:
  - After 3 bits, pulse `frame_start` with `serial_valid`=1 → `bit_count`=1; the next 7 bits form a clean word.
  - Assert `reset` mid-word → all outputs return to 0 within the same cycle.
